// File: rtl/cla_nibble_sequencer_if.sv
// Requester-side bundle for the nibble sequencer: operand request channel and
// result channel, each with a valid/ready handshake.
interface cla_nibble_sequencer_if #(
    parameter int NIBBLES = 4
) ();
    localparam int WIDTH = 4 * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output in_valid, a, b, sub, cin_in, out_ready,
        input  in_ready, out_valid, sum, carry_out
    );

    modport slave (
        input  in_valid, a, b, sub, cin_in, out_ready,
        output in_ready, out_valid, sum, carry_out
    );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// WIDTH-bit add/subtract built by streaming nibbles through one external registered
// 4-bit CLA adder. Optional signed-overflow output under CLA_SEQ_OVERFLOW_FLAG_EN.
module cla_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_nibble_sequencer_if.slave bus,
    output logic                 busy,
    output logic [3:0]           add_x,
    output logic [3:0]           add_y,
    output logic                 add_cin,
    input  logic [3:0]           add_z,
    input  logic                 add_cout
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
    ,
    output logic                 overflow
`endif
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_beff;
    logic             r_cin0;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [3:0]       w_a_nib [NIBBLES];
    logic [3:0]       w_b_nib [NIBBLES];

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign w_a_nib[gi] = r_a[4*gi +: 4];
            assign w_b_nib[gi] = r_beff[4*gi +: 4];
        end
    endgenerate

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry;
    assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_state_next = S_RUN;
            S_RUN:   if (r_idx == LAST_IDX) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // After the first issue the adder's registered cout is exactly the carry into
    // the nibble being issued now, so it is passed straight through.
    always_comb begin
        add_x   = 4'h0;
        add_y   = 4'h0;
        add_cin = 1'b0;
        if (r_state == S_RUN) begin
            add_x   = w_a_nib[r_idx];
            add_y   = w_b_nib[r_idx];
            add_cin = (r_idx == '0) ? r_cin0 : add_cout;
        end
    end

`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
    logic r_overflow;
    assign overflow = r_overflow;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_beff  <= '0;
            r_cin0  <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
            r_overflow <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a    <= bus.a;
                        r_beff <= bus.sub ? ~bus.b : bus.b;
                        r_cin0 <= bus.sub | bus.cin_in;
                        r_idx  <= '0;
                    end
                end
                S_RUN: begin
                    // Result of the previous issue lands one nibble behind r_idx.
                    for (int n = 1; n < NIBBLES; n++) begin
                        if (r_idx == IDX_W'(n)) r_sum[4*(n-1) +: 4] <= add_z;
                    end
                    r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
                end
                S_DRAIN: begin
                    r_sum[WIDTH-4 +: 4] <= add_z;
                    r_carry             <= add_cout;
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
                    r_overflow <= (r_a[WIDTH-1] == r_beff[WIDTH-1]) &&
                                  (add_z[3] != r_a[WIDTH-1]);
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer: registered 4-bit adder model, directed plan cases
// and random operations checked against whole-word arithmetic.
module tb_cla_nibble_sequencer;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [3:0] add_x, add_y, add_z;
    logic       add_cin, add_cout;
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
    logic       overflow;
`endif

    int vec_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    cla_nibble_sequencer_if #(.NIBBLES(N)) bus ();

    cla_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .add_x    (add_x),
        .add_y    (add_y),
        .add_cin  (add_cin),
        .add_z    (add_z),
        .add_cout (add_cout)
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
        ,
        .overflow (overflow)
`endif
    );

    // External registered 4-bit adder shared with the controller.
    always_ff @(posedge clk) begin
        {add_cout, add_z} <= {1'b0, add_x} + {1'b0, add_y} + {4'h0, add_cin};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Carry entering bit 4*k of x + y + c.
    function automatic logic carry_into(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input int k);
        logic [W:0] mask;
        logic [W:0] s;
        if (k == 0) return c;
        mask = ({{W{1'b0}}, 1'b1} << (4 * k)) - 1;
        s = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {{W{1'b0}}, c};
        return s[4*k];
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                          input logic tc, input int hold, input string name);
        logic [W-1:0] beff;
        logic         cin0;
        logic [W:0]   full;
        logic [3:0]   ex, ey;
        logic         ec;
        logic         eov;
        beff = ts ? ~tbv : tbv;
        cin0 = ts ? 1'b1 : tc;
        full = {1'b0, ta} + {1'b0, beff} + {{W{1'b0}}, cin0};
        eov  = (ta[W-1] == beff[W-1]) && (full[W-1] != ta[W-1]);

        vec_count++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            err_count++;
            $display("FAIL %s idle: in_ready=%b out_valid=%b required 1/0", name, bus.in_ready, bus.out_valid);
        end
        bus.in_valid = 1'b1;
        bus.a = ta;
        bus.b = tbv;
        bus.sub = ts;
        bus.cin_in = tc;
        tick();
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);

        for (int k = 0; k <= N; k++) begin
            ex = 4'h0;
            ey = 4'h0;
            ec = 1'b0;
            if (k < N) begin
                ex = ta[4*k +: 4];
                ey = beff[4*k +: 4];
                ec = carry_into(ta, beff, cin0, k);
            end
            vec_count++;
            if ({add_x, add_y, add_cin} !== {ex, ey, ec} || bus.in_ready !== 1'b0 ||
                busy !== 1'b1 || bus.out_valid !== 1'b0) begin
                err_count++;
                $display("FAIL %s issue%0d: x=%h y=%h cin=%b rdy=%b busy=%b ov=%b required x=%h y=%h cin=%b rdy=0 busy=1 ov=0",
                         name, k, add_x, add_y, add_cin, bus.in_ready, busy, bus.out_valid, ex, ey, ec);
            end
            tick();
        end

        vec_count++;
        if (bus.out_valid !== 1'b1 || bus.sum !== full[W-1:0] || bus.carry_out !== full[W] || busy !== 1'b0) begin
            err_count++;
            $display("FAIL %s result: out_valid=%b sum=%h carry=%b busy=%b required 1 %h %b 0",
                     name, bus.out_valid, bus.sum, bus.carry_out, busy, full[W-1:0], full[W]);
        end
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
        vec_count++;
        if (overflow !== eov) begin
            err_count++;
            $display("FAIL %s overflow: got %b required %b", name, overflow, eov);
        end
`endif

        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            tick();
            vec_count++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== full[W-1:0] ||
                bus.carry_out !== full[W]) begin
                err_count++;
                $display("FAIL %s hold%0d: out_valid=%b in_ready=%b sum=%h carry=%b required 1 0 %h %b",
                         name, h, bus.out_valid, bus.in_ready, bus.sum, bus.carry_out, full[W-1:0], full[W]);
            end
        end
        bus.in_valid = 1'b0;

        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        vec_count++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== full[W-1:0] ||
            bus.carry_out !== full[W]) begin
            err_count++;
            $display("FAIL %s release: out_valid=%b in_ready=%b sum=%h carry=%b required 0 1 %h %b",
                     name, bus.out_valid, bus.in_ready, bus.sum, bus.carry_out, full[W-1:0], full[W]);
        end
        $display("op %s: a=%h b=%h sub=%b cin=%b -> sum=%h carry=%b", name, ta, tbv, ts, tc, bus.sum, bus.carry_out);
    endtask

    task automatic check_reset_state(input string name);
        vec_count++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.sum !== '0 ||
            bus.carry_out !== 1'b0 || {add_x, add_y, add_cin} !== 9'h0) begin
            err_count++;
            $display("FAIL %s: rdy=%b ov=%b busy=%b sum=%h carry=%b x=%h y=%h cin=%b required 1 0 0 0000 0 0 0 0",
                     name, bus.in_ready, bus.out_valid, busy, bus.sum, bus.carry_out, add_x, add_y, add_cin);
        end
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
        vec_count++;
        if (overflow !== 1'b0) begin
            err_count++;
            $display("FAIL %s overflow: got %b required 0", name, overflow);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        bus.cin_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");
        $display("reset released");
    endtask

    task automatic test_add();
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, "add_basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "add_ripple");
    endtask

    task automatic test_sub();
        run_op(16'h1000, 16'h0001, 1'b1, 1'b0, 0, "sub_noborrow");
        run_op(16'h0001, 16'h0002, 1'b1, 1'b1, 0, "sub_borrow");
    endtask

    task automatic test_backpressure();
        run_op(16'hA5A5, 16'h1111, 1'b0, 1'b0, 10, "backpressure");
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, "after_bp");
    endtask

    task automatic test_reset_abort();
        bus.in_valid = 1'b1;
        bus.a = 16'h4321;
        bus.b = 16'h1234;
        bus.sub = 1'b0;
        bus.cin_in = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("abort");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "post_abort");
    endtask

    task automatic test_cin_in();
        run_op(16'h0005, 16'h0003, 1'b0, 1'b1, 0, "cin_in");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_abort();
        test_cin_in();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule
